// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcode and port-index constants for the ALU arbiter
package alu_arbiter_pkg;

    localparam logic [3:0] ALUC_ADD  = 4'b0000;
    localparam logic [3:0] ALUC_SUB  = 4'b0100;
    localparam logic [3:0] ALUC_AND  = 4'b0001;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0010;
    localparam logic [3:0] ALUC_LUI  = 4'b0110;
    localparam logic [3:0] ALUC_SLL  = 4'b0011;
    localparam logic [3:0] ALUC_SRL  = 4'b0111;
    localparam logic [3:0] ALUC_SRA  = 4'b1111;
    localparam logic [3:0] ALUC_HADS = 4'b1011;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/alu_rsp_slot.sv
// rtl/alu_rsp_slot.sv - one-deep registered response slot with valid/ready
module alu_rsp_slot #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] s_in,
    input  logic         z_in,
    output logic         rs_valid,
    input  logic         rs_ready,
    output logic [W-1:0] rs_s,
    output logic         rs_z
);

    // Load wins over drain so a slot emptying this cycle can be refilled at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            rs_valid <= 1'b0;
            rs_s     <= '0;
            rs_z     <= 1'b0;
        end else if (load) begin
            rs_valid <= 1'b1;
            rs_s     <= s_in;
            rs_z     <= z_in;
        end else if (rs_valid && rs_ready) begin
            rs_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one external combinational ALU
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR = 1'b1,
    parameter int W  = 32
) (
    input  logic         clock,
    input  logic         reset,

    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic [3:0]   r0_aluc,

    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    input  logic [3:0]   r1_aluc,

    output logic         rs0_valid,
    input  logic         rs0_ready,
    output logic [W-1:0] rs0_s,
    output logic         rs0_z,

    output logic         rs1_valid,
    input  logic         rs1_ready,
    output logic [W-1:0] rs1_s,
    output logic         rs1_z,

    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_aluc,
    input  logic [W-1:0] alu_s,
    input  logic         alu_z
);

    logic last_grant;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic p0_wins;

    // A port may issue only if its response slot is empty or draining this cycle.
    assign elig0 = r0_valid && (!rs0_valid || rs0_ready);
    assign elig1 = r1_valid && (!rs1_valid || rs1_ready);

    // Under contention port 0 wins unless round-robin says it went last.
    assign p0_wins = RR ? (last_grant != P0) : 1'b1;

    // Grant is held off during reset so no request is accepted in that cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            grant0 = elig0 && (!elig1 || p0_wins);
            grant1 = elig1 && !grant0;
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // Steer the granted port's operands to the shared ALU; idle drives zeros.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_aluc = ALUC_ADD;
        if (grant0) begin
            alu_a    = r0_a;
            alu_b    = r0_b;
            alu_aluc = r0_aluc;
        end else if (grant1) begin
            alu_a    = r1_a;
            alu_b    = r1_b;
            alu_aluc = r1_aluc;
        end
    end

    // Last-grant pointer moves only on a grant; reset points at port 1 so port 0 goes first.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= P1;
        end else if (grant0) begin
            last_grant <= P0;
        end else if (grant1) begin
            last_grant <= P1;
        end
    end

    alu_rsp_slot #(.W(W)) u_slot0 (
        .clock    (clock),
        .reset    (reset),
        .load     (grant0),
        .s_in     (alu_s),
        .z_in     (alu_z),
        .rs_valid (rs0_valid),
        .rs_ready (rs0_ready),
        .rs_s     (rs0_s),
        .rs_z     (rs0_z)
    );

    alu_rsp_slot #(.W(W)) u_slot1 (
        .clock    (clock),
        .reset    (reset),
        .load     (grant1),
        .s_in     (alu_s),
        .z_in     (alu_z),
        .rs_valid (rs1_valid),
        .rs_ready (rs1_ready),
        .rs_s     (rs1_s),
        .rs_z     (rs1_z)
    );

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: port 0 is the pipeline EXE stage and port 1 is the I/O / debug side-channel.
- Arbitrates per cycle (round-robin or fixed priority) and drives the shared ALU's a/b/aluc.
- Registers the result and zero flag into a one-deep response slot per requester, with valid/ready handshakes on both sides.
- Sits between the requesters and the ALU; the ALU itself is instantiated outside and wired to the alu_* ports.

Parameters:
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- W, 32: operand/result width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_valid  in  1  port-0 request valid.
- r0_ready  out  1  port-0 request accepted this cycle.
- r0_a  in  W  port-0 operand a.
- r0_b  in  W  port-0 operand b.
- r0_aluc  in  4  port-0 ALU opcode.
- r1_valid, r1_ready, r1_a, r1_b, r1_aluc  same as port 0, for port 1.
- rs0_valid  out  1  port-0 response valid.
- rs0_ready  in  1  port-0 consumer takes the response.
- rs0_s  out  W  port-0 result.
- rs0_z  out  1  port-0 zero flag.
- rs1_valid, rs1_ready, rs1_s, rs1_z  same as rs0, for port 1.
- alu_a  out  W  to shared ALU a.
- alu_b  out  W  to shared ALU b.
- alu_aluc  out  4  to shared ALU aluc.
- alu_s  in  W  from shared ALU s.
- alu_z  in  1  from shared ALU z.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high (`reset`).
- Reset values:
  - rs0_valid = rs1_valid = 0.
  - rs0_s = rs1_s = 0; rs0_z = rs1_z = 0.
  - last-grant pointer = 1, so port 0 wins the first contention.
- Eligibility: eligX = rX_valid & (~rsX_valid | rsX_ready). A slot draining this cycle may be refilled in the same cycle.
- Grant, combinational, at most one per cycle:
  - Only one port eligible: grant it.
  - Both eligible, RR = 1: grant the port not equal to the last-grant pointer.
  - Both eligible, RR = 0: grant port 0.
- rX_ready = grantX. The request is accepted on the rising edge where rX_valid & rX_ready.
- ALU drive:
  - While granted, alu_a/alu_b/alu_aluc = granted port's a/b/aluc. The opcode is passed through unmodified, including 4'b1011 (hamming distance); the arbiter does not decode opcodes.
  - No grant: alu_a = 0, alu_b = 0, alu_aluc = 4'b0000.
- Latency and throughput:
  - Accept at edge N → rsX_valid = 1 after edge N, holding alu_s/alu_z as sampled at that edge.
  - Aggregate throughput is 1 op/cycle.
- Response slot, per port, in priority order:
  - Granted: load the result and set valid.
  - Else if rsX_valid & rsX_ready: clear valid; data is don't-care but holds its value.
  - Else: hold.
- Round-robin pointer: updates to the granted port index only on a cycle with a grant. With no grant it holds.
- Stall: a full slot with rsX_ready = 0 blocks only that port. The other port may take every cycle. No head-of-line blocking across ports.
- Invariants:
  - Never both rX_ready high in one cycle.
  - A response is never overwritten before it is consumed.
- Reset mid-operation: pending responses are discarded (valid → 0) and the pointer returns to 1. A request presented in the reset cycle is not accepted; r0_ready = r1_ready = 0 while reset = 1.
- Requester rule: inputs must be held stable while rX_valid = 1 and rX_ready = 0. The arbiter does not check this.

Decomposition:
- Shared package: ALUC opcode constants (ADD 4'b0000, SUB 4'b0100, AND 4'b0001, OR 4'b0101, XOR 4'b0010, LUI 4'b0110, SLL 4'b0011, SRL 4'b0111, SRA 4'b1111, HADS 4'b1011) and the port-index constants P0 = 0, P1 = 1.
- One natural sub-module, alu_rsp_slot: the one-deep response register with valid/ready, instantiated once per port.
- Grant logic and pointer stay in the top level.

Test Plan:
- Port-0 ADD, a = 5, b = 3, aluc = 0000, port 1 idle → r0_ready = 1 that cycle; next cycle rs0_valid = 1, rs0_s = 8, rs0_z = 0.
- Both ports SUB 7−7 continuously, RR = 1, both rs_ready = 1 → grants alternate 0,1,0,1 starting with 0; every response has s = 0, z = 1.
- rs0_ready = 0 with rs0 slot full, both ports requesting → r0_ready stays 0 while r1 is accepted every cycle. Raising rs0_ready → r0 is accepted in that same cycle.
- RR = 0, both ports requesting continuously → port 1 is never granted while r0_valid = 1. Dropping r0_valid → port 1 is granted the next cycle.
- Port-1 HADS, a = 0xF0F0_0000, b = 0x0000_0000 → rs1_s = 8; during the grant cycle alu_aluc = 1011.
- Reset asserted while rs0_valid = 1 and rs1_valid = 1 → after the edge both valids = 0 and both data = 0. First contention after reset grants port 0.
